// File: rtl/wc_fifo_pkg.sv
// Shared helpers for the width-converting FIFO: pointer/level width derivation.
package wc_fifo_pkg;

  // Pointer width is at least one bit so SIZE==1 still elaborates.
  function automatic int unsigned ptr_width(input int unsigned size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

  function automatic int unsigned level_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/wc_fifo_ptr.sv
// Circular pointer register advancing by STEP words with modulo-SIZE wrap.
module wc_fifo_ptr #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned STEP = 1,
  parameter int unsigned PW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [PW-1:0] ptr
);

  localparam logic [PW:0] Size = (PW + 1)'(SIZE);
  localparam logic [PW:0] Step = (PW + 1)'(STEP);

  logic [PW:0]   sum;
  logic [PW:0]   wrapped;
  logic [PW-1:0] ptr_d;

  // STEP <= SIZE, so a single conditional subtract completes the modulo.
  always_comb begin
    sum     = {1'b0, ptr} + Step;
    wrapped = (sum >= Size) ? (sum - Size) : sum;
    ptr_d   = ptr;
    if (clr) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = wrapped[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_d;
    end
  end

endmodule

// File: rtl/wc_fifo.sv
// Width-converting FIFO: K words in per write, J words out per read, SIZE-word circular store.
module wc_fifo
  import wc_fifo_pkg::*;
#(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned K        = 2,
  parameter int unsigned J        = 1,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned LW      = level_width(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               w_en,
  input  logic               r_en,
  input  logic [WIDTH*K-1:0] par_in,
  output logic [WIDTH*J-1:0] par_out,
  output logic               valid,
  output logic               ready,
  output logic               empty,
  output logic               full,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [LW-1:0]      level,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned PW = ptr_width(SIZE);

  localparam logic [LW-1:0] ReadyMax = LW'(SIZE - K);
  localparam logic [LW-1:0] RdWords  = LW'(J);
  localparam logic [LW-1:0] WrWords  = LW'(K);
  localparam logic [LW-1:0] FullLvl  = LW'(SIZE);
  localparam logic [LW-1:0] AfLvl    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AeLvl    = LW'(AE_LEVEL);

  if (SIZE < K || SIZE < J || K == 0 || J == 0) begin : g_bad_params
    $error("wc_fifo: SIZE must be >= max(K,J) and K,J must be nonzero");
  end

  logic [WIDTH-1:0] mem [0:SIZE-1];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_acc, rd_acc;
  logic [PW-1:0]    widx [K];
  logic [PW-1:0]    ridx [J];
  logic [WIDTH*J-1:0] rd_words;

  // Status decodes from the registered level only.
  assign level        = level_q;
  assign ready        = (level_q <= ReadyMax);
  assign empty        = (level_q < RdWords);
  assign full         = (level_q == FullLvl);
  assign almost_full  = (level_q >= AfLvl);
  assign almost_empty = (level_q <= AeLvl);

  assign wr_acc = w_en && ready && !flush;
  assign rd_acc = r_en && !empty && !flush;

  wc_fifo_ptr #(.SIZE(SIZE), .STEP(K), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (wr_acc),
    .ptr (wr_ptr)
  );

  wc_fifo_ptr #(.SIZE(SIZE), .STEP(J), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (rd_acc),
    .ptr (rd_ptr)
  );

  // Per-word indices wrap individually so an access may straddle the array end.
  for (genvar i = 0; i < K; i++) begin : g_widx
    logic [PW:0] s;
    logic [PW:0] w;
    assign s       = {1'b0, wr_ptr} + (PW + 1)'(i);
    assign w       = (s >= (PW + 1)'(SIZE)) ? (s - (PW + 1)'(SIZE)) : s;
    assign widx[i] = w[PW-1:0];
  end

  for (genvar i = 0; i < J; i++) begin : g_ridx
    logic [PW:0] s;
    logic [PW:0] w;
    assign s       = {1'b0, rd_ptr} + (PW + 1)'(i);
    assign w       = (s >= (PW + 1)'(SIZE)) ? (s - (PW + 1)'(SIZE)) : s;
    assign ridx[i] = w[PW-1:0];
    assign rd_words[i*WIDTH +: WIDTH] = mem[ridx[i]];
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < K; i++) begin
        mem[widx[i]] <= par_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Level fits in LW bits after the combined add/subtract, so modular arithmetic is exact.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      if (wr_acc) level_d = level_d + WrWords;
      if (rd_acc) level_d = level_d - RdWords;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q   <= '0;
      par_out   <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      level_q <= level_d;
      if (flush) begin
        valid     <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        valid <= rd_acc;
        if (rd_acc) par_out <= rd_words;
        if (w_en && !ready) overflow <= 1'b1;
        if (r_en && empty) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wc_fifo.sv
// Randomised and directed bench for wc_fifo against a queue-based word model.
module tb_wc_fifo;

  localparam int unsigned SIZE = 8;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned K = 2;
  localparam int unsigned J = 3;
  localparam int unsigned AF = 6;
  localparam int unsigned AE = 1;
  localparam int unsigned LW = $clog2(SIZE + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               w_en = 1'b0;
  logic               r_en = 1'b0;
  logic [WIDTH*K-1:0] par_in = '0;
  logic [WIDTH*J-1:0] par_out;
  logic               valid, ready, empty, full, almost_full, almost_empty;
  logic [LW-1:0]      level;
  logic               overflow, underflow;

  int passed = 0;
  int total  = 0;

  logic [7:0]  q [$];
  logic [23:0] m_par = '0;
  logic        m_valid = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  wc_fifo #(
    .SIZE(SIZE), .WIDTH(WIDTH), .K(K), .J(J), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .w_en         (w_en),
    .r_en         (r_en),
    .par_in       (par_in),
    .par_out      (par_out),
    .valid        (valid),
    .ready        (ready),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".level"}, 64'(level), 64'(n));
    check({tag, ".empty"}, 64'(empty), 64'(n < J));
    check({tag, ".ready"}, 64'(ready), 64'(n <= SIZE - K));
    check({tag, ".full"}, 64'(full), 64'(n == SIZE));
    check({tag, ".afull"}, 64'(almost_full), 64'(n >= AF));
    check({tag, ".aempty"}, 64'(almost_empty), 64'(n <= AE));
    check({tag, ".valid"}, 64'(valid), 64'(m_valid));
    check({tag, ".par_out"}, 64'(par_out), 64'(m_par));
    check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    check({tag, ".underflow"}, 64'(underflow), 64'(m_unf));
  endtask

  // One clock with the given requests; model updated from pre-edge occupancy.
  task automatic step(input string tag, input bit w, input bit r, input bit f,
                      input logic [15:0] d);
    bit w_ok, r_ok;
    w_en = w; r_en = r; flush = f; par_in = d;
    w_ok = w && (q.size() <= SIZE - K);
    r_ok = r && (q.size() >= J);
    @(posedge clk);
    if (f) begin
      q.delete();
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && !w_ok) m_ovf = 1'b1;
      if (r && !r_ok) m_unf = 1'b1;
      m_valid = r_ok;
      if (r_ok) for (int i = 0; i < J; i++) m_par[i*8 +: 8] = q.pop_front();
      if (w_ok) for (int i = 0; i < K; i++) q.push_back(d[i*8 +: 8]);
    end
    #1;
    check_all(tag);
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic pack/unpack ordering
    step("wr1", 1, 0, 0, 16'h0201);
    step("wr2", 1, 0, 0, 16'h0403);
    step("rd1", 0, 1, 0, 16'h0000);
    check("rd1.word", 64'(par_out), 64'h030201);
    step("idle", 0, 0, 0, 16'h0000);

    // Fill to full, then overflow
    step("flush0", 0, 0, 1, 16'h0000);
    for (int i = 0; i < 4; i++) step("fill", 1, 0, 0, 16'(16'h1110 + 16'(i) * 16'h0202));
    step("ovf", 1, 0, 0, 16'hEEEE);
    check("ovf.level", 64'(level), 64'd8);

    // Stream 01..18 across several pointer wraps
    step("flush1", 0, 0, 1, 16'h0000);
    for (int n = 0; n < 12; n++) begin
      step("stream", 1, (n % 2) == 1, 0, {8'(2 * n + 2), 8'(2 * n + 1)});
    end
    while (q.size() >= J) step("drain", 0, 1, 0, 16'h0000);
    step("unf", 0, 1, 0, 16'h0000);

    // Level 7 with both requests: read taken, write refused
    step("flush2", 0, 0, 1, 16'h0000);
    for (int i = 0; i < 4; i++) step("l7w", 1, 0, 0, 16'(16'h2120 + 16'(i) * 16'h0202));
    step("l7r", 0, 1, 0, 16'h0000);
    step("l7w2", 1, 0, 0, 16'h3938);
    step("both7", 1, 1, 0, 16'h4140);
    check("both7.level", 64'(level), 64'd4);
    step("l3w", 1, 0, 0, 16'h4342);
    step("l3r", 0, 1, 0, 16'h0000);
    step("both3", 1, 1, 0, 16'h4544);
    check("both3.level", 64'(level), 64'd2);

    // Flush overrides simultaneous requests; par_out holds
    step("flush3", 1, 1, 1, 16'h5555);

    // Asynchronous reset mid-stream
    step("pre_rst", 1, 0, 0, 16'h6766);
    step("pre_rst2", 1, 0, 0, 16'h6968);
    #2 rst = 1'b0;
    q.delete(); m_par = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1 check_all("async_rst");
    #1 rst = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
